// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 5-stage MIPS pipeline.
// Latency: all controls are combinational from state and inputs (0-cycle); only state, cnt and perf counters are registered.
// Backpressure: load-use stalls IF/ID for 1 cycle; mul/div holds IF/ID/EX for MD_LATENCY-1 cycles.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   id_rs/id_rt/id_use_*  source operands of the ID instruction and whether they are read
//   id_jump               ID holds j/jal/jr
//   ex_mem_read/ex_wr_reg EX holds a load and its destination register
//   ex_branch_tkn         branch in EX resolved taken
//   ex_md_op              EX holds mult/div
//   pc_write, if_id_*     front-end enables and flush
//   id_ex_*               ID/EX bubble, flush and hold
//   ex_mem_bubble         EX/MEM bubble while mul/div is held
//   md_busy               held cycles after the first one of a mul/div
//   perf_stalls/flushes   event counters (PIPE_PERF_CNT_EN only, else tied to 0)
//
// Optional feature macro: PIPE_PERF_CNT_EN enables the perf counters.

module pipeline_hazard_ctrl #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 4,
   parameter int PERF_W     = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4:0]        id_rs,
   input  logic [4:0]        id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_jump,
   input  logic              ex_mem_read,
   input  logic [4:0]        ex_wr_reg,
   input  logic              ex_branch_tkn,
   input  logic              ex_md_op,
   output logic              pc_write,
   output logic              if_id_write,
   output logic              if_id_flush,
   output logic              id_ex_stall,
   output logic              id_ex_flush,
   output logic              id_ex_hold,
   output logic              ex_mem_bubble,
   output logic              md_busy,
   output logic [PERF_W-1:0] perf_stalls,
   output logic [PERF_W-1:0] perf_flushes
);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      MD_BUSY = 1'b1
   } state_t;

   // A latency of 1 never stalls; the load value is only meaningful when >= 2.
   localparam logic             MD_STALLS = (MD_LATENCY >= 2);
   localparam logic [CNT_W-1:0] CNT_LOAD  = (MD_LATENCY >= 2) ? CNT_W'(MD_LATENCY - 2) : '0;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic lu;
   logic md_start;
   logic md_cont;
   logic md_hold;

   assign lu = ex_mem_read && (ex_wr_reg != 5'd0) &&
               ((id_use_rs && (id_rs == ex_wr_reg)) ||
                (id_use_rt && (id_rt == ex_wr_reg)));

   // First EX cycle of a mul/div is held from IDLE; the remaining held cycles
   // are counted down in MD_BUSY. cnt == 0 in MD_BUSY is the release cycle.
   assign md_start = (state_q == IDLE) && ex_md_op && MD_STALLS;
   assign md_cont  = (state_q == MD_BUSY) && (cnt_q != '0);
   assign md_hold  = md_start || md_cont;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (ex_branch_tkn) begin
         // Branch wins over any mul/div in EX; the FSM never leaves IDLE on it.
         state_d = IDLE;
         cnt_d   = '0;
      end else if (md_start) begin
         state_d = MD_BUSY;
         cnt_d   = CNT_LOAD;
      end else if (md_cont) begin
         cnt_d   = cnt_q - CNT_W'(1);
      end else if (state_q == MD_BUSY) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      if_id_flush   = 1'b0;
      id_ex_stall   = 1'b0;
      id_ex_flush   = 1'b0;
      id_ex_hold    = 1'b0;
      ex_mem_bubble = 1'b0;
      md_busy       = 1'b0;
      if (reset) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (ex_branch_tkn) begin
         // Squashes the ID instruction, so any load-use on it is moot.
         if_id_flush = 1'b1;
         id_ex_flush = 1'b1;
      end else if (md_hold) begin
         // lu and jump are masked here and looked at again on the release cycle.
         pc_write      = 1'b0;
         if_id_write   = 1'b0;
         id_ex_hold    = 1'b1;
         ex_mem_bubble = 1'b1;
         md_busy       = md_cont;
      end else if (lu) begin
         pc_write    = 1'b0;
         if_id_write = 1'b0;
         id_ex_stall = 1'b1;
      end else if (id_jump) begin
         if_id_flush = 1'b1;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   logic [PERF_W-1:0] perf_stalls_q;
   logic [PERF_W-1:0] perf_flushes_q;

   // Reset cycles are excluded: the reset branch clears instead of counting.
   always_ff @(posedge clk) begin
      if (reset) begin
         perf_stalls_q  <= '0;
         perf_flushes_q <= '0;
      end else begin
         perf_stalls_q  <= perf_stalls_q + PERF_W'(!pc_write);
         perf_flushes_q <= perf_flushes_q + PERF_W'(if_id_flush);
      end
   end

   assign perf_stalls  = perf_stalls_q;
   assign perf_flushes = perf_flushes_q;
`else
   assign perf_stalls  = '0;
   assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

   localparam int L      = 4;
   localparam int PERF_W = 32;

   logic clk = 1'b0;
   logic reset;
   logic [4:0] id_rs, id_rt, ex_wr_reg;
   logic id_use_rs, id_use_rt, id_jump, ex_mem_read, ex_branch_tkn, ex_md_op;
   logic pc_write, if_id_write, if_id_flush, id_ex_stall, id_ex_flush;
   logic id_ex_hold, ex_mem_bubble, md_busy;
   logic [PERF_W-1:0] perf_stalls, perf_flushes;

   pipeline_hazard_ctrl #(.MD_LATENCY(L), .CNT_W(4), .PERF_W(PERF_W)) dut (
      .clk(clk), .reset(reset),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_jump(id_jump), .ex_mem_read(ex_mem_read), .ex_wr_reg(ex_wr_reg),
      .ex_branch_tkn(ex_branch_tkn), .ex_md_op(ex_md_op),
      .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
      .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .id_ex_hold(id_ex_hold),
      .ex_mem_bubble(ex_mem_bubble), .md_busy(md_busy),
      .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
   );

   always #5 clk = ~clk;

   // Output vector order: pc_write, if_id_write, if_id_flush, id_ex_stall,
   // id_ex_flush, id_ex_hold, ex_mem_bubble, md_busy
   logic [7:0] obs;
   assign obs = {pc_write, if_id_write, if_id_flush, id_ex_stall,
                 id_ex_flush, id_ex_hold, ex_mem_bubble, md_busy};

   localparam logic [7:0] V_RST  = 8'b0010_1000;
   localparam logic [7:0] V_DEF  = 8'b1100_0000;
   localparam logic [7:0] V_LU   = 8'b0001_0000;
   localparam logic [7:0] V_BR   = 8'b1110_1000;
   localparam logic [7:0] V_JMP  = 8'b1110_0000;
   localparam logic [7:0] V_HLD1 = 8'b0000_0110;
   localparam logic [7:0] V_HLDB = 8'b0000_0111;

   int checks = 0;
   int errors = 0;

   // Reference model: md_pos = EX cycles the current mul/div has already spent
   // there (0 = none). The op is held on EX cycles 1..L-1 and released on cycle L.
   int md_pos = 0;
   logic [PERF_W-1:0] ref_stalls = '0;
   logic [PERF_W-1:0] ref_flushes = '0;

   function automatic logic ref_lu();
      logic hit;
      hit = 1'b0;
      if (ex_mem_read && ex_wr_reg != 5'd0) begin
         if (id_use_rs && id_rs == ex_wr_reg) hit = 1'b1;
         if (id_use_rt && id_rt == ex_wr_reg) hit = 1'b1;
      end
      return hit;
   endfunction

   function automatic logic [7:0] ref_out();
      logic held;
      if (reset) return V_RST;
      if (ex_branch_tkn) return V_BR;
      if (md_pos == 0) held = ex_md_op && (L >= 2);
      else             held = (md_pos + 1 < L);
      if (held) return {6'b000001, 1'b1, md_pos != 0};
      if (ref_lu()) return V_LU;
      if (id_jump) return V_JMP;
      return V_DEF;
   endfunction

   always @(posedge clk) begin
      logic [7:0] e;
      e = ref_out();
      if (reset) begin
         ref_stalls  = '0;
         ref_flushes = '0;
      end else begin
         if (!e[7]) ref_stalls  = ref_stalls + 1;
         if (e[5])  ref_flushes = ref_flushes + 1;
      end
      if (reset || ex_branch_tkn) md_pos = 0;
      else if (md_pos == 0)       md_pos = (ex_md_op && L >= 2) ? 1 : 0;
      else                        md_pos = (md_pos + 1 < L) ? md_pos + 1 : 0;
   end

   task automatic drive(input logic rst, input logic bt, input logic md, input logic jmp,
                        input logic mr, input logic [4:0] wr, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urs, input logic urt);
      reset = rst; ex_branch_tkn = bt; ex_md_op = md; id_jump = jmp;
      ex_mem_read = mr; ex_wr_reg = wr; id_rs = rs; id_rt = rt;
      id_use_rs = urs; id_use_rt = urt;
   endtask

   task automatic idle_in();
      drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      // Reset with competing events present must still give the reset vector.
      drive(1, 1, 1, 1, 1, 5'd8, 5'd8, 5'd8, 1, 1);
      next_cycle();
      @(negedge clk);
      checks++;
      if (obs !== V_RST) begin
         errors++; $display("FAIL reset_outputs got=%b want=%b", obs, V_RST);
      end
      checks++;
      if (perf_stalls !== '0 || perf_flushes !== '0) begin
         errors++; $display("FAIL reset_perf got=%0d/%0d want=0/0", perf_stalls, perf_flushes);
      end
      next_cycle();
      idle_in();
      @(negedge clk);
      checks++;
      if (obs !== V_DEF) begin
         errors++; $display("FAIL post_reset_default got=%b want=%b", obs, V_DEF);
      end
      next_cycle();
   endtask

   task automatic test_load_use();
      drive(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd3, 1, 1);
      @(negedge clk);
      checks++;
      if (obs !== V_LU) begin
         errors++; $display("FAIL lu_rs got=%b want=%b", obs, V_LU);
      end
      next_cycle();
      drive(0, 0, 0, 0, 0, 5'd0, 5'd8, 5'd3, 1, 1);
      @(negedge clk);
      checks++;
      if (obs !== V_DEF) begin
         errors++; $display("FAIL lu_after got=%b want=%b", obs, V_DEF);
      end
      next_cycle();
      drive(0, 0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 1, 1);
      @(negedge clk);
      checks++;
      if (obs !== V_LU) begin
         errors++; $display("FAIL lu_rt got=%b want=%b", obs, V_LU);
      end
      next_cycle();
      drive(0, 0, 0, 0, 1, 5'd9, 5'd1, 5'd9, 1, 0);
      @(negedge clk);
      checks++;
      if (obs !== V_DEF) begin
         errors++; $display("FAIL lu_rt_unused got=%b want=%b", obs, V_DEF);
      end
      next_cycle();
      drive(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
      @(negedge clk);
      checks++;
      if (obs !== V_DEF) begin
         errors++; $display("FAIL lu_reg0 got=%b want=%b", obs, V_DEF);
      end
      next_cycle();
      idle_in();
   endtask

   task automatic test_branch();
      drive(0, 1, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0);
      @(negedge clk);
      checks++;
      if (obs !== V_BR) begin
         errors++; $display("FAIL branch_with_lu got=%b want=%b", obs, V_BR);
      end
      next_cycle();
      // Illegal branch + mul/div: branch wins and the FSM must not start holding.
      drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      @(negedge clk);
      checks++;
      if (obs !== V_BR) begin
         errors++; $display("FAIL branch_md got=%b want=%b", obs, V_BR);
      end
      next_cycle();
      idle_in();
      @(negedge clk);
      checks++;
      if (obs !== V_DEF) begin
         errors++; $display("FAIL branch_md_after got=%b want=%b", obs, V_DEF);
      end
      next_cycle();
   endtask

   task automatic test_jump();
      drive(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      @(negedge clk);
      checks++;
      if (obs !== V_JMP) begin
         errors++; $display("FAIL jump got=%b want=%b", obs, V_JMP);
      end
      next_cycle();
      drive(0, 0, 0, 1, 1, 5'd4, 5'd4, 5'd0, 1, 0);
      @(negedge clk);
      checks++;
      if (obs !== V_LU) begin
         errors++; $display("FAIL jump_lu got=%b want=%b", obs, V_LU);
      end
      next_cycle();
      drive(0, 0, 0, 1, 0, 5'd0, 5'd4, 5'd0, 1, 0);
      @(negedge clk);
      checks++;
      if (obs !== V_JMP) begin
         errors++; $display("FAIL jump_after_lu got=%b want=%b", obs, V_JMP);
      end
      next_cycle();
      idle_in();
   endtask

   task automatic test_md();
      logic [7:0] want [4];
      int holds, busy;
      want[0] = V_HLD1; want[1] = V_HLDB; want[2] = V_HLDB; want[3] = V_LU;
      // Single op; a load-use is present from cycle 2 and must surface only on release.
      for (int c = 0; c < 4; c++) begin
         if (c == 0) drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
         else        drive(0, 0, 1, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0);
         @(negedge clk);
         checks++;
         if (obs !== want[c]) begin
            errors++; $display("FAIL md_cycle%0d got=%b want=%b", c + 1, obs, want[c]);
         end
         next_cycle();
      end
      idle_in();
      next_cycle();
      // Two back-to-back ops occupying EX for 2*L cycles.
      holds = 0; busy = 0;
      for (int c = 0; c < 2 * L; c++) begin
         drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
         @(negedge clk);
         if (id_ex_hold) holds++;
         if (md_busy) busy++;
         next_cycle();
      end
      checks++;
      if (holds != 6) begin
         errors++; $display("FAIL md_b2b_holds got=%0d want=6", holds);
      end
      checks++;
      if (busy != 4) begin
         errors++; $display("FAIL md_b2b_busy got=%0d want=4", busy);
      end
      idle_in();
      @(negedge clk);
      checks++;
      if (obs !== V_DEF) begin
         errors++; $display("FAIL md_b2b_after got=%b want=%b", obs, V_DEF);
      end
      next_cycle();
   endtask

   task automatic test_md_reset();
      drive(0, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      next_cycle();
      next_cycle();
      drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      @(negedge clk);
      checks++;
      if (obs !== V_RST) begin
         errors++; $display("FAIL md_reset_during got=%b want=%b", obs, V_RST);
      end
      next_cycle();
      idle_in();
      @(negedge clk);
      checks++;
      if (obs !== V_DEF) begin
         errors++; $display("FAIL md_reset_after got=%b want=%b", obs, V_DEF);
      end
      next_cycle();
   endtask

   task automatic test_perf();
      logic [PERF_W-1:0] exp_cnt;
`ifdef PIPE_PERF_CNT_EN
      exp_cnt = 1;
`else
      exp_cnt = 0;
`endif
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      next_cycle();
      drive(0, 0, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0);
      next_cycle();
      drive(0, 1, 0, 0, 1, 5'd8, 5'd8, 5'd0, 1, 0);
      next_cycle();
      idle_in();
      @(negedge clk);
      checks++;
      if (perf_stalls !== exp_cnt) begin
         errors++; $display("FAIL perf_stalls got=%0d want=%0d", perf_stalls, exp_cnt);
      end
      checks++;
      if (perf_flushes !== exp_cnt) begin
         errors++; $display("FAIL perf_flushes got=%0d want=%0d", perf_flushes, exp_cnt);
      end
      next_cycle();
   endtask

   task automatic test_random();
      logic [7:0] e;
      logic [PERF_W-1:0] es, ef;
      for (int n = 0; n < 3000; n++) begin
         drive($urandom_range(63) == 0,
               (md_pos == 0) && ($urandom_range(7) == 0),
               $urandom_range(3) == 0,
               $urandom_range(5) == 0,
               $urandom_range(1) == 1,
               5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
               $urandom_range(1) == 1, $urandom_range(1) == 1);
         @(negedge clk);
         e = ref_out();
         checks++;
         if (obs !== e) begin
            errors++; $display("FAIL rand_out n=%0d got=%b want=%b", n, obs, e);
         end
`ifdef PIPE_PERF_CNT_EN
         es = ref_stalls; ef = ref_flushes;
`else
         es = '0; ef = '0;
`endif
         checks++;
         if (perf_stalls !== es || perf_flushes !== ef) begin
            errors++; $display("FAIL rand_perf n=%0d got=%0d/%0d want=%0d/%0d",
                               n, perf_stalls, perf_flushes, es, ef);
         end
         next_cycle();
      end
      idle_in();
   endtask

   initial begin
      idle_in();
      reset = 1'b1;
      test_reset();
      test_load_use();
      test_branch();
      test_jump();
      test_md();
      test_md_reset();
      test_perf();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
